// File: rtl/mux_8x1_arbiter_pkg.sv
// Shared constants, state encoding and small helpers for the round-robin
// arbiter that drives an 8:1 mux.
package mux_8x1_arbiter_pkg;

    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_8x1_arbiter_if.sv
// Request/data/grant bundle between requesters (master) and the arbiter (slave).
interface mux_8x1_arbiter_if;
    import mux_8x1_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] i;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] s;
    logic             out;
    logic             busy;

    modport master (
        output req, i,
        input  grant, s, out, busy
    );

    modport slave (
        input  req, i,
        output grant, s, out, busy
    );

endinterface

// File: rtl/mux_8x1_arbiter_mux.sv
// Plain 8:1 bit multiplexer: out = i[s].
module mux_8x1
    import mux_8x1_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i,
    input  logic [SEL_W-1:0] s,
    output logic             out
);

    assign out = i[s];

endmodule

// File: rtl/mux_8x1_arbiter.sv
// Round-robin arbiter with bounded hold time; the winner's index selects the
// shared 8:1 mux and the mux output is forced low whenever nobody holds the grant.
module mux_8x1_arbiter
    import mux_8x1_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
)
(
    input  logic               clk,
    input  logic               rst,
    mux_8x1_arbiter_if.slave   bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e             state;
    logic [N_REQ-1:0]   grant_q;
    logic [SEL_W-1:0]   s_q;
    logic [SEL_W-1:0]   ptr;
    logic               busy_q;
    logic [HOLD_W-1:0]  hold_cnt;

    logic               holder_req;
    logic               hold_ok;
    logic [SEL_W-1:0]   scan_base;
    logic               found;
    logic [SEL_W-1:0]   winner;
    logic               mux_out;

    // First requester at or after base, wrapping 7 -> 0. Scanning from the
    // farthest offset down lets the nearest hit overwrite the result last.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] base);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = base + SEL_W'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign holder_req = bus.req[s_q];
    assign hold_ok    = holder_req && (hold_cnt < HOLD_LAST);

    // On release or timeout the holder drops to lowest priority, so the scan
    // starts just past it; a lone holder is found last and re-granted.
    assign scan_base       = (state == IDLE) ? ptr : s_q + SEL_W'(1);
    assign {found, winner} = rr_pick(bus.req, scan_base);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state    <= IDLE;
            grant_q  <= '0;
            s_q      <= '0;
            busy_q   <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        grant_q  <= onehot(winner);
                        s_q      <= winner;
                        busy_q   <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (hold_ok) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end else begin
                        ptr      <= s_q + SEL_W'(1);
                        hold_cnt <= '0;
                        if (found) begin
                            grant_q <= onehot(winner);
                            s_q     <= winner;
                        end else begin
                            // s keeps its last value while idle
                            state   <= IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    mux_8x1 u_mux (
        .i   (bus.i),
        .s   (s_q),
        .out (mux_out)
    );

    assign bus.grant = grant_q;
    assign bus.s     = s_q;
    assign bus.busy  = busy_q;
    assign bus.out   = mux_out & busy_q;

endmodule

// File: tb/tb_mux_8x1_arbiter.sv
// Directed bench for mux_8x1_arbiter (MAX_HOLD = 4): reset, round-robin order,
// timeout handover, data path, simultaneous release and mid-grant reset.
module tb_mux_8x1_arbiter;
    import mux_8x1_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    mux_8x1_arbiter_if bus ();

    mux_8x1_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] g, input logic [2:0] sel,
                               input logic b);
        check({tag, ".grant"}, bus.grant, g);
        check({tag, ".s"}, {5'b0, bus.s}, {5'b0, sel});
        check({tag, ".busy"}, {7'b0, bus.busy}, {7'b0, b});
    endtask

    logic [7:0] exp_grant;
    logic [7:0] timeout_seq [12];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.req  = 8'hFF;
        bus.i    = 8'hFF;

        // Reset holds everything low even across clock edges with requests pending
        step();
        step();
        check_state("reset", 8'h00, 3'd0, 1'b0);
        check("reset.out", {7'b0, bus.out}, 8'h00);
        rst = 1'b0;
        step();
        check_state("first_grant", 8'h01, 3'd0, 1'b1);

        // Round-robin: each holder drops its request after its second grant cycle
        for (int k = 0; k < 8; k++) begin
            exp_grant = 8'h01 << k;
            bus.req   = 8'hFF;
            step();
            check($sformatf("rr_hold%0d", k), bus.grant, exp_grant);
            bus.req = ~exp_grant;
            step();
            exp_grant = 8'h01 << ((k + 1) % 8);
            check($sformatf("rr_next%0d", k), bus.grant, exp_grant);
            check($sformatf("rr_busy%0d", k), {7'b0, bus.busy}, 8'h01);
        end

        // Timeout with req = 05: 01 x4, 04 x4, 01 x4, never idle
        rst = 1'b1;
        #1;
        check_state("rst_pulse", 8'h00, 3'd0, 1'b0);
        rst     = 1'b0;
        bus.req = 8'h05;
        timeout_seq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h04, 8'h04, 8'h04, 8'h04,
                        8'h01, 8'h01, 8'h01, 8'h01};
        for (int c = 0; c < 12; c++) begin
            step();
            check($sformatf("timeout_c%0d", c), bus.grant, timeout_seq[c]);
            check($sformatf("timeout_busy%0d", c), {7'b0, bus.busy}, 8'h01);
        end

        // Release with no other request: idle, s keeps last value, out gated low
        bus.req = 8'h00;
        step();
        check_state("idle_after_release", 8'h00, 3'd0, 1'b0);
        check("idle.out", {7'b0, bus.out}, 8'h00);

        // Data path on requester 5 (ptr is 1, so the scan reaches 5)
        bus.req = 8'h20;
        bus.i   = 8'b0010_0000;
        step();
        check_state("dp_grant5", 8'h20, 3'd5, 1'b1);
        check("dp_out1", {7'b0, bus.out}, 8'h01);
        bus.i = 8'b1101_1111;
        #1;
        check("dp_out0", {7'b0, bus.out}, 8'h00);
        // Lone holder times out and is re-granted
        for (int c = 0; c < 4; c++) step();
        check_state("dp_regrant5", 8'h20, 3'd5, 1'b1);
        bus.i = 8'b0010_0000;
        #1;
        check("dp_out1_again", {7'b0, bus.out}, 8'h01);
        bus.req = 8'h00;
        step();
        check_state("dp_release", 8'h00, 3'd5, 1'b0);
        check("dp_release.out", {7'b0, bus.out}, 8'h00);

        // Simultaneous release of holder 2 with req[6] and req[1] rising
        bus.req = 8'h04;
        step();
        check_state("sim_grant2", 8'h04, 3'd2, 1'b1);
        step();
        bus.req = 8'h42;
        step();
        check_state("sim_handover", 8'h40, 3'd6, 1'b1);

        // Other requesters changing while 6 holds do not disturb the grant
        bus.req = 8'hC1;
        step();
        check_state("no_preempt", 8'h40, 3'd6, 1'b1);

        // Mid-grant asynchronous reset
        bus.req = 8'h00;
        step();
        check("pre_mid.busy", {7'b0, bus.busy}, 8'h00);
        bus.req = 8'h10;
        bus.i   = 8'h10;
        step();
        check_state("mid_grant4", 8'h10, 3'd4, 1'b1);
        check("mid_grant4.out", {7'b0, bus.out}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check_state("mid_reset", 8'h00, 3'd0, 1'b0);
        check("mid_reset.out", {7'b0, bus.out}, 8'h00);
        #1;
        rst     = 1'b0;
        bus.req = 8'h11;
        step();
        check_state("post_reset", 8'h01, 3'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_8x1_arbiter.md
MUX_8X1_ARBITER -- requirements
Module: mux_8x1_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, meaning maximum consecutive cycles one requester holds the grant; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  8  request per requester; req[k] high = requester k wants the shared mux output.
REQ-005 i  input  8  data per requester; i[k] is requester k's bit.
REQ-006 grant  output  8  one-hot grant, registered; all-zero when idle.
REQ-007 s  output  3  registered select driven to the 8x1 mux; equals index of the granted requester.
REQ-008 out  output  1  shared output; i[s] while busy, 0 while idle.
REQ-009 busy  output  1  registered; high while a grant is held.

Function
REQ-010 Two states, IDLE and GRANT; state, grant, s, busy, ptr (3-bit next-priority index) and hold_cnt (8-bit) are registers.
REQ-011 Winner selection: first k with req[k]=1, scanning ptr, ptr+1, ... ptr+7 modulo 8 (wrap-around from 7 to 0).
REQ-012 IDLE: if req != 0 at a rising edge, go to GRANT at that edge with grant = one-hot(winner), s = winner, busy = 1, hold_cnt = 0; else stay IDLE.
REQ-013 Latency: request sampled at edge n produces grant/s/busy valid immediately after edge n (1 cycle from request assertion to grant).
REQ-014 GRANT, hold: if req[s]=1 and hold_cnt < MAX_HOLD-1, stay; grant and s unchanged; hold_cnt increments by 1.
REQ-015 GRANT, release: if req[s]=0, set ptr = s+1 mod 8, then arbitrate among the other 7 requesters per REQ-011 within the same edge.
REQ-016 GRANT, timeout: if req[s]=1 and hold_cnt = MAX_HOLD-1, set ptr = s+1 mod 8 and arbitrate over all 8 requesters.
REQ-017 Handover: when REQ-015/016 find a winner, new grant applies at that edge with no idle cycle; hold_cnt = 0.
REQ-018 Timeout with only the current holder requesting: the holder is re-granted; hold_cnt = 0.
REQ-019 Release with no other request: go to IDLE; grant = 0, busy = 0; s keeps last value.
REQ-020 Simultaneous release by holder and new requests from others: handover per REQ-017, never IDLE.
REQ-021 grant is one-hot or zero at all times; grant[s] = 1 whenever busy = 1.
REQ-022 out is combinational from i and the registered s, gated by busy; no additional latency.
REQ-023 Request changes from non-granted requesters during GRANT do not affect grant until release or timeout.

Reset
REQ-024 rst high forces, asynchronously: state IDLE, grant 8'b0, s 3'b000, busy 0, out 0, ptr 0, hold_cnt 0.
REQ-025 Reset asserted mid-grant drops the grant immediately; first arbitration after release uses ptr 0.
REQ-026 Deassertion of rst takes effect at the first rising edge of clk at which rst is low.

Structure
REQ-027 Shared package holds N_REQ = 8, SEL_W = 3, HOLD_W = 8 and the state enumeration {IDLE, GRANT}.
REQ-028 Datapath instantiates the existing mux_8x1 as the single sub-module (ports i, s, out); output gating by busy is done in this block.
REQ-029 Round-robin priority search is a combinational function inside this block, not a separate module.

Verification
REQ-030 Reset: rst=1 with req=8'hFF -> grant=0, s=0, busy=0, out=0; release rst, next edge -> grant=8'h01, s=0.
REQ-031 Round-robin: req=8'hFF held, each holder drops req for one cycle after its 2nd grant cycle -> grant order 01,02,04,...,80,01 (wrap 7->0).
REQ-032 Timeout: MAX_HOLD=4, req=8'h05 held -> grant 01 for 4 cycles, then 04 for 4 cycles, then 01, no idle cycle.
REQ-033 Data path: grant on k=5, i=8'b00100000 -> out=1; i=8'b11011111 -> out=0; after release with req=0 -> busy=0, out=0.
REQ-034 Simultaneous events: holder 2 drops req in the same cycle req[6] and req[1] rise -> next grant 8'h40 (ptr=3 scan), no IDLE.
REQ-035 Mid-operation reset: rst pulsed while grant=8'h10 -> grant=0 asynchronously; with req=8'h11 after release -> grant=8'h01.
